operand_stack: RTL and testbench

LIFO operand store for the stack CPU. It sits between the control unit/instruction memory and the ALU. It accepts immediates via push and discards via pop. On alu_wb it collapses the top two entries into the ALU result. The top two entries are presented continuously to the ALU operand inputs, and overflow/underflow/illegal-op conditions are reported as sticky flags.

---
 rtl/operand_stack.sv | 148 ++++++++++++++
 tb/tb_operand_stack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// LIFO operand store for the stack CPU: push/pop/replace/ALU write-back with
// TOS/NOS presented combinationally and sticky overflow/underflow/op_error flags.
module operand_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  alu_wb,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out_1st,
  output logic [DATA_WIDTH-1:0] data_out_2nd,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  op_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO_C   = CNT_WIDTH'(2);

  // Operation code is {alu_wb, push, pop}; anything not listed is illegal.
  typedef enum logic [2:0] {
    OP_IDLE    = 3'b000,
    OP_POP     = 3'b001,
    OP_PUSH    = 3'b010,
    OP_REPLACE = 3'b011,
    OP_ALU_WB  = 3'b100
  } op_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [CNT_WIDTH-1:0]  cnt_m1;
  logic [CNT_WIDTH-1:0]  cnt_m2;
  logic [AW-1:0]         tos_idx;
  logic [AW-1:0]         nos_idx;
  logic [AW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  set_ovf;
  logic                  set_unf;
  logic                  set_ope;
  logic                  has_one;
  logic                  has_two;
  logic [2:0]            op_code;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  ope_q;

  assign op_code = {alu_wb, push, pop};
  assign cnt_m1  = cnt_q - ONE_C;
  assign cnt_m2  = cnt_q - TWO_C;
  assign tos_idx = cnt_m1[AW-1:0];
  assign nos_idx = cnt_m2[AW-1:0];
  assign has_one = (cnt_q >= ONE_C);
  assign has_two = (cnt_q >= TWO_C);

  assign count        = cnt_q;
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_C);
  assign data_out_1st = has_one ? mem[tos_idx] : '0;
  assign data_out_2nd = has_two ? mem[nos_idx] : '0;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign op_error     = ope_q;

  // Rejected operations leave count and storage untouched; only a flag is raised.
  always_comb begin
    cnt_nxt = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_ope = 1'b0;
    case (op_code)
      OP_IDLE: ;
      OP_PUSH: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_idx  = cnt_q[AW-1:0];
          wr_data = data_in;
          cnt_nxt = cnt_q + ONE_C;
        end else begin
          set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (has_one) cnt_nxt = cnt_m1;
        else         set_unf = 1'b1;
      end
      OP_REPLACE: begin
        if (has_one) begin
          wr_en   = 1'b1;
          wr_idx  = tos_idx;
          wr_data = data_in;
        end else begin
          set_unf = 1'b1;
        end
      end
      OP_ALU_WB: begin
        if (has_two) begin
          wr_en   = 1'b1;
          wr_idx  = nos_idx;
          wr_data = alu_result;
          cnt_nxt = cnt_m1;
        end else begin
          set_unf = 1'b1;
        end
      end
      default: set_ope = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      if (wr_en) mem[wr_idx] <= wr_data;
    end
  end

  // A new error event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ope_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clear_err) | set_ovf;
      unf_q <= (unf_q & ~clear_err) | set_unf;
      ope_q <= (ope_q & ~clear_err) | set_ope;
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed and randomized bench for operand_stack, checked against a
// queue-based model of the stack contents and sticky flags.
module tb_operand_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset, push, pop, alu_wb, clear_err;
  logic [DW-1:0] data_in, alu_result;
  logic [DW-1:0] data_out_1st, data_out_2nd;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow, op_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stack contents bottom..top plus the three flags.
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_unf, m_ope;

  always #5 clock = ~clock;

  operand_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .alu_wb(alu_wb),
    .data_in(data_in), .alu_result(alu_result), .clear_err(clear_err),
    .data_out_1st(data_out_1st), .data_out_2nd(data_out_2nd), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .op_error(op_error)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic w, input logic p, input logic o,
                            input logic [DW-1:0] din, input logic [DW-1:0] ar,
                            input logic clr, input logic rst);
    logic ev_ovf, ev_unf, ev_ope;
    logic [DW-1:0] tmp;
    ev_ovf = 1'b0; ev_unf = 1'b0; ev_ope = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_ope = 1'b0;
      return;
    end
    if (!w && p && !o) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(din);
      else ev_ovf = 1'b1;
    end else if (!w && !p && o) begin
      if (exp_q.size() >= 1) tmp = exp_q.pop_back();
      else ev_unf = 1'b1;
    end else if (!w && p && o) begin
      if (exp_q.size() >= 1) exp_q[exp_q.size()-1] = din;
      else ev_unf = 1'b1;
    end else if (w && !p && !o) begin
      if (exp_q.size() >= 2) begin
        tmp = exp_q.pop_back();
        exp_q[exp_q.size()-1] = ar;
      end else ev_unf = 1'b1;
    end else if (w || p || o) begin
      ev_ope = 1'b1;
    end
    m_ovf = (m_ovf & ~clr) | ev_ovf;
    m_unf = (m_unf & ~clr) | ev_unf;
    m_ope = (m_ope & ~clr) | ev_ope;
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic cyc(input logic w, input logic p, input logic o,
                     input logic [DW-1:0] din, input logic [DW-1:0] ar,
                     input logic clr, input logic rst);
    alu_wb = w; push = p; pop = o; data_in = din; alu_result = ar;
    clear_err = clr; reset = rst;
    @(posedge clock);
    model_step(w, p, o, din, ar, clr, rst);
    #1;
    alu_wb = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".count"}, DW'(count), DW'(sz));
    check({tag, ".empty"}, DW'(empty), DW'(sz == 0));
    check({tag, ".full"},  DW'(full),  DW'(sz == DEPTH));
    check({tag, ".tos"}, data_out_1st, (sz >= 1) ? exp_q[sz-1] : '0);
    check({tag, ".nos"}, data_out_2nd, (sz >= 2) ? exp_q[sz-2] : '0);
    check({tag, ".ovf"}, DW'(overflow),  DW'(m_ovf));
    check({tag, ".unf"}, DW'(underflow), DW'(m_unf));
    check({tag, ".ope"}, DW'(op_error),  DW'(m_ope));
  endtask

  initial begin
    int r;
    logic [2:0] ill;
    reset = 1'b1; push = 1'b0; pop = 1'b0; alu_wb = 1'b0; clear_err = 1'b0;
    data_in = '0; alu_result = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_ope = 1'b0;
    #1;

    // Reset then idle
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0);
    check_state("reset_idle");
    check("reset_idle.empty_c", DW'(empty), 32'd1);

    // push 5, push 3, alu_wb 8
    cyc(0, 1, 0, 32'h5, 32'h0, 0, 0);
    cyc(0, 1, 0, 32'h3, 32'h0, 0, 0);
    check_state("two_push");
    check("two_push.tos_c", data_out_1st, 32'h3);
    check("two_push.nos_c", data_out_2nd, 32'h5);
    cyc(1, 0, 0, 32'h0, 32'h8, 0, 0);
    check_state("alu_wb");
    check("alu_wb.tos_c", data_out_1st, 32'h8);
    check("alu_wb.count_c", DW'(count), 32'd1);

    // Fill, overflow, pop, clear_err
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) cyc(0, 1, 0, DW'(i), 32'h0, 0, 0);
    check_state("filled");
    cyc(0, 1, 0, 32'h99, 32'h0, 0, 0);
    check_state("overflow");
    check("overflow.tos_c", data_out_1st, DW'(DEPTH));
    check("overflow.flag_c", DW'(overflow), 32'd1);
    cyc(0, 0, 1, 32'h0, 32'h0, 0, 0);
    check_state("full_pop");
    check("full_pop.tos_c", data_out_1st, DW'(DEPTH - 1));
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 0);
    check_state("clear_ovf");
    check("clear_ovf.flag_c", DW'(overflow), 32'd0);
    for (int i = 0; i < 1; i++) cyc(0, 1, 0, 32'hAB, 32'h0, 0, 0);
    cyc(0, 1, 1, 32'hCD, 32'h0, 0, 0);
    check_state("full_replace");
    cyc(1, 0, 0, 32'h0, 32'h1234, 0, 0);
    check_state("full_alu_wb");

    // Underflow from empty
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(0, 0, 1, 32'h0, 32'h0, 0, 0);
    check_state("empty_pop");
    check("empty_pop.unf_c", DW'(underflow), 32'd1);
    cyc(0, 1, 0, 32'h7, 32'h0, 0, 0);
    check_state("push7");
    cyc(1, 0, 0, 32'h0, 32'h55, 0, 0);
    check_state("one_alu_wb");
    check("one_alu_wb.tos_c", data_out_1st, 32'h7);

    // Replace and illegal combination
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(0, 1, 0, 32'hA, 32'h0, 0, 0);
    cyc(0, 1, 1, 32'hB, 32'h0, 0, 0);
    check_state("replace");
    check("replace.tos_c", data_out_1st, 32'hB);
    cyc(1, 1, 0, 32'hC, 32'h0, 0, 0);
    check_state("illegal");
    check("illegal.ope_c", DW'(op_error), 32'd1);

    // Set wins over clear, then reset during push
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(0, 0, 1, 32'h0, 32'h0, 1, 0);
    check_state("set_wins");
    check("set_wins.unf_c", DW'(underflow), 32'd1);
    cyc(0, 1, 0, 32'h77, 32'h0, 0, 1);
    check_state("reset_push");
    check("reset_push.tos_c", data_out_1st, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic rst_r, clr_r;
      logic [DW-1:0] din_r, ar_r;
      r     = $urandom_range(0, 99);
      rst_r = ($urandom_range(0, 99) == 0);
      clr_r = ($urandom_range(0, 19) == 0);
      din_r = $urandom;
      ar_r  = $urandom;
      if (r < 38)      cyc(0, 1, 0, din_r, ar_r, clr_r, rst_r);
      else if (r < 58) cyc(0, 0, 1, din_r, ar_r, clr_r, rst_r);
      else if (r < 68) cyc(0, 1, 1, din_r, ar_r, clr_r, rst_r);
      else if (r < 88) cyc(1, 0, 0, din_r, ar_r, clr_r, rst_r);
      else if (r < 95) cyc(0, 0, 0, din_r, ar_r, clr_r, rst_r);
      else begin
        ill = 3'($urandom_range(5, 7));
        cyc(ill[2], ill[1], ill[0], din_r, ar_r, clr_r, rst_r);
      end
      check_state("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
